// File: rtl/sipo_ctrl_pkg.sv
// Shared types for the serial frame controller.
// FSM state encoding and serial line bit levels.
package sipo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sipo_shift.sv
// Serial-in/parallel-out shift register, MSB received first.
// Ports: clk, rst (async active-low), shift_en, clr (sync), din -> q[WIDTH-1:0].
module sipo_shift #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {q[WIDTH-2:0], din};
        end
    end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller: start detect, WIDTH data bits, stop check, valid/ready output.
// Ports: clk, rst (async active-low), in, bit_en, out_ready, clr_err ->
//   out_data, out_valid, busy, frame_err, overrun [, parity_err].
// Optional macro PARITY_CHECK_EN adds an even-parity bit and parity_err.
module sipo_frame_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             bit_en,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
`ifdef PARITY_CHECK_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t         state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           shift_en;
    logic           clr;
    logic           commit;
    logic           bad_stop;
    logic           drop;
    logic [WIDTH-1:0] word;

`ifdef PARITY_CHECK_EN
    logic par_bad, par_bad_nx;
    logic par_pulse;
`endif

    sipo_shift #(.WIDTH(WIDTH)) u_shift (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .clr      (clr),
        .din      (in),
        .q        (word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        shift_en = 1'b0;
        clr      = 1'b0;
        commit   = 1'b0;
        bad_stop = 1'b0;
`ifdef PARITY_CHECK_EN
        par_bad_nx = par_bad;
        par_pulse  = 1'b0;
`endif
        if (bit_en) begin
            unique case (state)
                IDLE: begin
                    if (in == START_BIT) begin
                        state_nx = SHIFT;
                        cnt_nx   = '0;
                        clr      = 1'b1;
`ifdef PARITY_CHECK_EN
                        par_bad_nx = 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    shift_en = 1'b1;
                    cnt_nx   = cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end
                end
                PARITY: begin
`ifdef PARITY_CHECK_EN
                    // even parity: data plus parity bit must XOR to 0
                    par_bad_nx = ^{word, in};
                    par_pulse  = ^{word, in};
                    state_nx   = STOP;
`else
                    state_nx   = IDLE;
`endif
                end
                STOP: begin
                    if (in == STOP_BIT) begin
`ifdef PARITY_CHECK_EN
                        commit = !par_bad;
`else
                        commit = 1'b1;
`endif
                    end else begin
                        bad_stop = 1'b1;
                    end
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bad    <= par_bad_nx;
            parity_err <= par_pulse;
        end
    end
`endif

    // a good frame is lost when the previous word is still held unconsumed
    assign drop = commit && out_valid && !out_ready;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            if (commit && !drop) begin
                out_data  <= word;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
